// File: rtl/mode_seq_pkg.sv
// Shared types and default timing constants for the mode sequencer.
package mode_seq_pkg;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_FWD,
        DIR_BACK,
        DIR_JUMP
    } dir_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 4;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stability counter,
// filtered level and a one-cycle release (1->0) pulse.
module button_debounce
    import mode_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic release_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             vld_p0;
    logic             vld_p1;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             level_d;
    logic             differs;

    // A button held through reset must be seen low once before a press can
    // be accepted, otherwise its eventual release would count as a step.
    assign differs = (sync_p1 != level_q) && (armed || level_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            level_q <= 1'b0;
            level_d <= 1'b0;
        end else begin
            // stage p0 -> p1: synchroniser
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            if (vld_p1 && !sync_p1) begin
                armed <= 1'b1;
            end
            // debounce: toggle on the edge the count would reach DEBOUNCE_CYCLES
            level_d <= level_q;
            if (!differs) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                level_q <= ~level_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level         = level_q;
    assign release_pulse = level_d & ~level_q;

endmodule

// File: rtl/mode_sequencer.sv
// One-hot mode sequencer driven by debounced button releases and direct jumps.
// Optional long-press-to-home behaviour on advance is enabled by `define LONG_PRESS_EN.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int NUM_STATES      = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int WRAP            = 1,
`ifdef LONG_PRESS_EN
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
`endif
    parameter int IDX_W           = $clog2(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    input  logic                  retreat,
    input  logic                  jump_valid,
    input  logic [IDX_W-1:0]      jump_idx,
    output logic [NUM_STATES-1:0] en,
    output logic [IDX_W-1:0]      state_idx,
    output logic                  step_pulse,
    output logic                  wrapped
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATES - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_STATES);

    logic                  adv_level;
    logic                  adv_rel;
    logic                  ret_level;
    logic                  ret_rel;
    logic                  long_rel;
    logic                  unused_levels;
    dir_t                  dir;
    logic [IDX_W-1:0]      tgt;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  wrap_nxt;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_STATES-1:0] en_q;
    logic                  step_q;
    logic                  wrap_q;

    function automatic logic [NUM_STATES-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_STATES-1:0] v;
        for (int k = 0; k < NUM_STATES; k++) begin
            v[k] = (i == IDX_W'(k));
        end
        return v;
    endfunction

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv (
        .clk           (clk),
        .reset         (reset),
        .raw           (advance),
        .level         (adv_level),
        .release_pulse (adv_rel)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ret (
        .clk           (clk),
        .reset         (reset),
        .raw           (retreat),
        .level         (ret_level),
        .release_pulse (ret_rel)
    );

    assign unused_levels = adv_level ^ ret_level;

`ifdef LONG_PRESS_EN
    localparam int               HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;

    // Saturating hold timer; still valid in the release cycle because it
    // clears on the edge that follows the filtered level dropping.
    always_ff @(posedge clk) begin
        if (reset || !adv_level) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign long_rel = adv_rel && (hold_cnt == HOLD_MAX);
`else
    assign long_rel = 1'b0;
`endif

    always_comb begin
        dir = DIR_NONE;
        tgt = idx_q;
        if (jump_valid && ({1'b0, jump_idx} < NUM_EXT)) begin
            dir = DIR_JUMP;
            tgt = jump_idx;
        end else if (adv_rel && ret_rel) begin
            dir = DIR_NONE;
        end else if (long_rel) begin
            dir = DIR_JUMP;
            tgt = '0;
        end else if (adv_rel) begin
            dir = DIR_FWD;
        end else if (ret_rel) begin
            dir = DIR_BACK;
        end
    end

    always_comb begin
        idx_nxt  = idx_q;
        wrap_nxt = 1'b0;
        case (dir)
            DIR_JUMP: idx_nxt = tgt;
            DIR_FWD: begin
                if (idx_q != LAST_IDX) begin
                    idx_nxt = idx_q + 1'b1;
                end else if (WRAP != 0) begin
                    idx_nxt  = '0;
                    wrap_nxt = 1'b1;
                end
            end
            DIR_BACK: begin
                if (idx_q != '0) begin
                    idx_nxt = idx_q - 1'b1;
                end else if (WRAP != 0) begin
                    idx_nxt  = LAST_IDX;
                    wrap_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // en is registered alongside the index so it never glitches or goes zero
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            en_q   <= NUM_STATES'(1);
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_nxt;
            en_q   <= onehot(idx_nxt);
            step_q <= (idx_nxt != idx_q);
            wrap_q <= wrap_nxt;
        end
    end

    assign en         = en_q;
    assign state_idx  = idx_q;
    assign step_pulse = step_q;
    assign wrapped    = wrap_q;

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Parametrised successor to the 3-state button-driven enable selector.
- Steps through NUM_STATES one-hot modes on debounced button releases.
- Supports forward and backward stepping, direct jump, and wrap or saturate at the ends.
- Sits between the raw board push-buttons and the calculator's input/operator/result datapath stages; drives their enables.

Parameters:
- NUM_STATES, 3: number of modes (2..16); width of en.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a filtered button level changes (>=1).
- WRAP, 1: 1 = wrap end-to-end; 0 = saturate at first/last state.
- IDX_W, $clog2(NUM_STATES): width of state index ports.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- advance  input  1  raw (asynchronous) step-forward button, active-high.
- retreat  input  1  raw (asynchronous) step-backward button, active-high.
- jump_valid  input  1  synchronous single-cycle request to load jump_idx.
- jump_idx  input  IDX_W  target state for jump_valid.
- en  output  NUM_STATES  one-hot enable; bit i high when in state i.
- state_idx  output  IDX_W  binary current state.
- step_pulse  output  1  one-cycle pulse on the cycle state_idx changes.
- wrapped  output  1  one-cycle pulse when a step wrapped (last->0 or 0->last).

Behaviour:
- Reset (sampled on a clk edge while reset=1):
  - state_idx=0, en=1, step_pulse=0, wrapped=0.
  - Synchronisers, debounce counters and filtered levels cleared to 0.
  - Reset wins over every other input in the same cycle.
- Input conditioning, per button:
  - 2-flop synchroniser, then debounce.
  - Counter increments while the synced level differs from the filtered level; clears when they match.
  - Filtered level toggles on the edge where the counter would reach DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Release event: filtered level 1 in the previous cycle and 0 now (one cycle wide). Presses alone do nothing.
- Latency: a raw release first sampled at edge 0 updates state_idx/en at edge DEBOUNCE_CYCLES+2. step_pulse is high during the cycle following that edge.
- Next-state priority, evaluated each cycle:
  - 1. jump_valid with jump_idx < NUM_STATES -> load jump_idx. jump_idx >= NUM_STATES is ignored (no change, no pulse).
  - 2. advance-release and retreat-release in the same cycle -> no change.
  - 3. advance-release -> idx+1. At NUM_STATES-1: WRAP=1 -> 0 with wrapped=1; WRAP=0 -> hold, no pulse.
  - 4. retreat-release -> idx-1. At 0: WRAP=1 -> NUM_STATES-1 with wrapped=1; WRAP=0 -> hold, no pulse.
- Pulse rules:
  - step_pulse fires only if the index actually changes; a jump to the current index gives no pulse.
- en and state_idx are registered and glitch-free. en is decoded from a registered index, always exactly one-hot, never zero.
- Reset mid-debounce discards the pending edge: a button still held after reset must be released before it counts.

Optional Feature:
- Macro LONG_PRESS_EN.
- Defined:
  - Adds parameter LONG_PRESS_CYCLES (default 50_000_000).
  - If filtered advance stays high >= LONG_PRESS_CYCLES, its release loads state 0 instead of stepping.
  - step_pulse fires if the index changes; wrapped=0.
  - Hold counter saturates and clears on release or reset.
- Undefined: no hold counter; every release is a normal step.

Decomposition:
- Package mode_seq_pkg holds:
  - step-direction enum dir_t {DIR_NONE, DIR_FWD, DIR_BACK, DIR_JUMP}.
  - Default constants for DEBOUNCE_CYCLES and LONG_PRESS_CYCLES.
- Sub-module button_debounce (synchroniser, counter, filtered level, release pulse), instantiated once per button.
- Top level holds the priority arbiter, index register and one-hot decoder.

Test Plan (NUM_STATES=3, DEBOUNCE_CYCLES=4, WRAP=1 unless stated):
- Reset then 3 clean advance press/release cycles -> en 001->010->100->001; wrapped pulses once, on the 100->001 step; each change occurs at edge 6 after the raw release.
- Advance glitch high for 3 cycles -> no filtered change; en stays 001; no step_pulse.
- retreat release from state 0 -> state_idx=2, wrapped=1. Repeat with WRAP=0 -> stays 0, no step_pulse.
- jump_valid with jump_idx=1 in the same cycle as an advance release, from state 0 -> state_idx=1 (jump wins). jump_idx=3 -> ignored.
- Simultaneous advance and retreat releases aligned to the same cycle -> no change. Reset asserted while advance is held mid-debounce -> state 0; the later release is ignored.
- LONG_PRESS_EN with LONG_PRESS_CYCLES=20:
  - From state 2, hold advance 25 cycles then release -> state 0, wrapped=0.
  - Hold 10 cycles then release -> normal step.
